// File: rtl/bram_pkg.sv
// Mode codes and per-width depth limits for one 18 Kb half of a TDP36K,
// shared by the FIFO controller and the techmap parameter checks.
package bram_pkg;

   localparam logic [2:0] MODE_1   = 3'd0;
   localparam logic [2:0] MODE_2   = 3'd1;
   localparam logic [2:0] MODE_4   = 3'd2;
   localparam logic [2:0] MODE_9   = 3'd3;
   localparam logic [2:0] MODE_18  = 3'd4;
   localparam logic [2:0] MODE_36  = 3'd5;
   localparam logic [2:0] MODE_BAD = 3'd7;

   // Deepest address width one 18 Kb half supports at a given width; 0 = illegal width.
   function automatic int max_abits(input int dbits);
      case (dbits)
         1:       return 14;
         2:       return 13;
         4:       return 12;
         8, 9:    return 11;
         16, 18:  return 10;
         default: return 0;
      endcase
   endfunction

   function automatic logic [2:0] mode_of(input int dbits);
      case (dbits)
         1:       return MODE_1;
         2:       return MODE_2;
         4:       return MODE_4;
         8, 9:    return MODE_9;
         16, 18:  return MODE_18;
         32, 36:  return MODE_36;
         default: return MODE_BAD;
      endcase
   endfunction

endpackage

// File: rtl/bram_fifo_obuf.sv
// Two-entry output buffer with same-cycle bypass of the returning BRAM word.
// Latency 0 when empty; holds data while ready is low, never accepts a third word.
module bram_fifo_obuf
#(
   parameter int DBITS = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [DBITS-1:0] wr_data,
   output logic             valid,
   input  logic             ready,
   output logic [DBITS-1:0] data,
   output logic [1:0]       count
);

   logic [DBITS-1:0] mem [2];
   logic             head;
   logic             slot;
   logic             take;
   logic             from_mem;
   logic             store;

   assign valid    = (count != 2'd0) || wr_en;
   assign take     = valid && ready;
   assign from_mem = take && (count != 2'd0);
   // A word returning into an empty buffer that is taken at once never gets stored.
   assign store    = wr_en && !(take && (count == 2'd0));
   assign slot     = head ^ count[0];

   always_comb begin
      data = '0;
      if (count != 2'd0) begin
         data = mem[head];
      end else if (wr_en) begin
         data = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         head   <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (store) begin
            mem[slot] <= wr_data;
         end
         if (from_mem) begin
            head <= ~head;
         end
         count <= count + {1'b0, store} - {1'b0, from_mem};
      end
   end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller driving a simple-dual-port BRAM half; push-to-output latency 2 cycles.
// IN_READY_o drops when full or flushing; reads pause once the output buffer plus in-flight word reach 2.
module bram_fifo_ctrl
   import bram_pkg::*;
#(
   parameter int DBITS     = 18,
   parameter int ABITS     = 10,
   parameter int AF_THRESH = (1 << ABITS) - 4
) (
   input  logic             CLK_i,
   input  logic             RST_i,
   input  logic             FLUSH_i,
   input  logic             IN_VALID_i,
   output logic             IN_READY_o,
   input  logic [DBITS-1:0] IN_DATA_i,
   output logic             OUT_VALID_o,
   input  logic             OUT_READY_i,
   output logic [DBITS-1:0] OUT_DATA_o,
   output logic [ABITS:0]   COUNT_o,
   output logic             AFULL_o,
   output logic [ABITS-1:0] BRAM_WADDR_o,
   output logic [DBITS-1:0] BRAM_WDATA_o,
   output logic             BRAM_WEN_o,
   output logic [ABITS-1:0] BRAM_RADDR_o,
   output logic             BRAM_REN_o,
   input  logic [DBITS-1:0] BRAM_RDATA_i
);

   generate
      if (mode_of(DBITS) == MODE_BAD || mode_of(DBITS) == MODE_36 ||
          ABITS < 1 || ABITS > max_abits(DBITS)) begin : g_bad_param
         $error("bram_fifo_ctrl: DBITS/ABITS combination does not fit one 18 Kb half");
      end
   endgenerate

   localparam logic [ABITS:0] DEPTH  = {1'b1, {ABITS{1'b0}}};
   localparam logic [ABITS:0] AF_LVL = AF_THRESH[ABITS:0];

   logic [ABITS-1:0] wr_ptr;
   logic [ABITS-1:0] rd_ptr;
   logic [ABITS:0]   bram_occ;
   logic [ABITS:0]   count;
   logic [ABITS:0]   count_nxt;
   logic             afull;
   logic             inflight;
   logic             in_ready;
   logic             push;
   logic             pop;
   logic             issue;
   logic             out_valid;
   logic [DBITS-1:0] out_data;
   logic [1:0]       obuf_cnt;
   logic [2:0]       obuf_load;

   assign in_ready  = (count < DEPTH) && !FLUSH_i;
   // Gating with RST_i keeps both BRAM enables low for the whole reset pulse.
   assign push      = IN_VALID_i && in_ready && !RST_i;
   assign pop       = out_valid && OUT_READY_i && !FLUSH_i;
   assign obuf_load = {1'b0, obuf_cnt} + {2'b00, inflight};
   assign issue     = !RST_i && !FLUSH_i && (bram_occ != '0) &&
                      (obuf_load <= 3'd1 + {2'b00, pop});

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + (ABITS+1)'(1);
      end else if (pop && !push) begin
         count_nxt = count - (ABITS+1)'(1);
      end
   end

   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         bram_occ <= '0;
         count    <= '0;
         afull    <= 1'b0;
         inflight <= 1'b0;
      end else if (FLUSH_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         bram_occ <= '0;
         count    <= '0;
         afull    <= 1'b0;
         inflight <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ABITS'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + ABITS'(1);
         end
         if (push && !issue) begin
            bram_occ <= bram_occ + (ABITS+1)'(1);
         end else if (issue && !push) begin
            bram_occ <= bram_occ - (ABITS+1)'(1);
         end
         count    <= count_nxt;
         afull    <= (count_nxt >= AF_LVL);
         inflight <= issue;
      end
   end

   // A word returning during a flush is dropped rather than buffered.
   bram_fifo_obuf #(
      .DBITS (DBITS)
   ) u_obuf (
      .clk     (CLK_i),
      .rst     (RST_i),
      .flush   (FLUSH_i),
      .wr_en   (inflight && !FLUSH_i),
      .wr_data (BRAM_RDATA_i),
      .valid   (out_valid),
      .ready   (OUT_READY_i && !FLUSH_i),
      .data    (out_data),
      .count   (obuf_cnt)
   );

   assign IN_READY_o   = in_ready;
   assign OUT_VALID_o  = out_valid;
   assign OUT_DATA_o   = out_data;
   assign COUNT_o      = count;
   assign AFULL_o      = afull;
   assign BRAM_WADDR_o = wr_ptr;
   assign BRAM_WDATA_o = IN_DATA_i;
   assign BRAM_WEN_o   = push;
   assign BRAM_RADDR_o = rd_ptr;
   assign BRAM_REN_o   = issue;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl with a 16-deep, 18-bit configuration and a behavioural BRAM.
module tb_bram_fifo_ctrl;

   localparam int DBITS = 18;
   localparam int ABITS = 4;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [DBITS-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [DBITS-1:0] out_data;
   logic [ABITS:0]   count;
   logic             afull;
   logic [ABITS-1:0] waddr;
   logic [DBITS-1:0] wdata;
   logic             wen;
   logic [ABITS-1:0] raddr;
   logic             ren;
   logic [DBITS-1:0] rdata = '0;

   int tests = 0;
   int fails = 0;

   bram_fifo_ctrl #(
      .DBITS     (DBITS),
      .ABITS     (ABITS),
      .AF_THRESH (AFT)
   ) dut (
      .CLK_i        (clk),
      .RST_i        (rst),
      .FLUSH_i      (flush),
      .IN_VALID_i   (in_valid),
      .IN_READY_o   (in_ready),
      .IN_DATA_i    (in_data),
      .OUT_VALID_o  (out_valid),
      .OUT_READY_i  (out_ready),
      .OUT_DATA_o   (out_data),
      .COUNT_o      (count),
      .AFULL_o      (afull),
      .BRAM_WADDR_o (waddr),
      .BRAM_WDATA_o (wdata),
      .BRAM_WEN_o   (wen),
      .BRAM_RADDR_o (raddr),
      .BRAM_REN_o   (ren),
      .BRAM_RDATA_i (rdata)
   );

   always #5 clk = ~clk;

   logic [DBITS-1:0] bram [DEPTH];
   always @(posedge clk) begin
      if (wen) bram[waddr] <= wdata;
      if (ren) rdata <= bram[raddr];
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // Reference model: the FIFO is a queue of accepted words; BRAM traffic is tracked by counts.
   logic [DBITS-1:0] q[$];
   int  occ_m  = 0;
   int  outst_m = 0;
   int  nwr    = 0;
   int  nrd    = 0;
   bit  mon_en = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         occ_m = 0; outst_m = 0; nwr = 0; nrd = 0;
      end else if (mon_en) begin
         logic acc;
         logic tk;
         acc = in_valid && (q.size() < DEPTH) && !flush;
         tk  = out_valid && out_ready && !flush;
         chk("count", count, q.size());
         chk("afull", afull, q.size() >= AFT);
         chk("in_ready", in_ready, (q.size() < DEPTH) && !flush);
         chk("wen", wen, acc);
         if (wen) chk("waddr", waddr, nwr % DEPTH);
         if (ren) begin
            chk("raddr", raddr, nrd % DEPTH);
            chk("ren_with_data", occ_m > 0, 1'b1);
         end
         chk("obuf_bound", outst_m <= 2, 1'b1);
         if (out_valid) chk("valid_nonempty", q.size() != 0, 1'b1);
         if (tk && q.size() != 0) chk("order", out_data, q[0]);
         if (flush) begin
            q.delete();
            occ_m = 0; outst_m = 0; nwr = 0; nrd = 0;
         end else begin
            if (acc) q.push_back(in_data);
            if (tk && q.size() != 0) void'(q.pop_front());
            occ_m   += int'(wen) - int'(ren);
            outst_m += int'(ren) - int'(tk);
            nwr     += int'(wen);
            nrd     += int'(ren);
         end
      end
   end

   typedef struct {
      logic             iv;
      logic [DBITS-1:0] id;
      logic             ordy;
      logic             ov;
      logic [DBITS-1:0] od;
      logic [ABITS:0]   cnt;
      logic             we;
      logic             re;
      logic             ir;
   } vec_t;

   vec_t vt[4];

   task automatic drain();
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (count != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_done", count, 0);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, out_valid, 1'b1);
   endtask

   initial begin
      int  bubbles;
      bit  burst;

      vt[0] = '{1'b1, 18'h15A, 1'b1, 1'b0, 18'h0,   5'd0, 1'b1, 1'b0, 1'b1};
      vt[1] = '{1'b0, 18'h0,   1'b1, 1'b0, 18'h0,   5'd1, 1'b0, 1'b1, 1'b1};
      vt[2] = '{1'b0, 18'h0,   1'b1, 1'b1, 18'h15A, 5'd1, 1'b0, 1'b0, 1'b1};
      vt[3] = '{1'b0, 18'h0,   1'b1, 1'b0, 18'h0,   5'd0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk("reset_outputs",
          {out_valid, out_data, count, afull, wen, ren, waddr, raddr, in_ready},
          {1'b0, 18'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1});
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // first-word latency
      for (int i = 0; i < 4; i++) begin
         in_valid  = vt[i].iv;
         in_data   = vt[i].id;
         out_ready = vt[i].ordy;
         @(negedge clk);
         chk($sformatf("latency_vec%0d", i),
             {out_valid, out_data, count, wen, ren, in_ready},
             {vt[i].ov, vt[i].od, vt[i].cnt, vt[i].we, vt[i].re, vt[i].ir});
         @(posedge clk); #1;
      end

      // fill to full with no pops
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         in_data = 18'(32'h100 + k);
         @(negedge clk);
         chk($sformatf("fill_afull_%0d", k), afull, k >= AFT);
         chk($sformatf("fill_ready_%0d", k), in_ready, 1'b1);
         @(posedge clk); #1;
      end
      in_data   = 18'h3FF;
      out_ready = 1'b1;
      @(negedge clk);
      chk("full_ready", in_ready, 1'b0);
      chk("full_count", count, 16);
      chk("full_afull", afull, 1'b1);
      chk("full_head", out_data, 18'h100);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("full_pop_count", count, 15);
      chk("full_next_head", out_data, 18'h101);
      @(posedge clk); #1;
      drain();

      // continuous streaming
      bubbles   = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 1002; i++) begin
         in_valid = (i < 1000);
         in_data  = 18'(i * 7 + 3);
         @(negedge clk);
         if (i >= 2 && !out_valid) bubbles++;
         @(posedge clk); #1;
      end
      chk("stream_bubbles", bubbles, 0);
      drain();

      // random bursts with random back-pressure
      burst = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) burst = !burst;
         in_valid  = burst && ($urandom_range(0, 3) != 0);
         in_data   = 18'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      drain();

      // flush while a read is in flight, with a simultaneous push
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 18'h011;
      @(posedge clk); #1;
      in_data = 18'h022;
      @(negedge clk);
      chk("flush_setup_ren", ren, 1'b1);
      @(posedge clk); #1;
      flush   = 1'b1;
      in_data = 18'h077;
      @(negedge clk);
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      flush     = 1'b0;
      in_data   = 18'h0AA;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_flush_count", count, 0);
      chk("post_flush_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid("post_flush_first_valid");
      chk("post_flush_first_data", out_data, 18'h0AA);
      drain();

      // reset in the middle of traffic
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 18'(32'h200 + i);
         @(posedge clk); #1;
      end
      chk("pre_reset_nonempty", count != 0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_reset_outputs",
          {out_valid, out_data, count, afull, wen, ren, waddr, raddr, in_ready},
          {1'b0, 18'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1});
      @(posedge clk); #1;
      chk("in_reset_wen", wen, 1'b0);
      rst       = 1'b0;
      in_data   = 18'h3A5;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid("post_reset_first_valid");
      chk("post_reset_first_data", out_data, 18'h3A5);
      drain();

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
